// File: rtl/mac_acc_round_sat_if.sv
// Streaming bus between the dual-multiply stage, the accumulator and the audio
// output path: framed product terms in, one valid/ready PCM sample out.
interface mac_acc_round_sat_if #(
    parameter int PSIZE = 33,
    parameter int OUT_W = 16
);

    logic                    in_valid;
    logic                    in_first;
    logic                    in_last;
    logic signed [PSIZE-1:0] p;

    logic                    out_valid;
    logic                    out_ready;
    logic        [OUT_W-1:0] out_data;
    logic                    out_sat;

    // The producer of terms and consumer of samples.
    modport master (
        output in_valid,
        output in_first,
        output in_last,
        output p,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sat
    );

    // The accumulator block itself.
    modport slave (
        input  in_valid,
        input  in_first,
        input  in_last,
        input  p,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sat
    );

endinterface

// File: rtl/mac_acc_round_sat.sv
// Frame accumulator for the dual-multiply stage: sums a framed run of product
// terms, rounds half-up, shifts down and saturates to an OUT_W-bit PCM sample,
// and holds the sample in a single-entry valid/ready output register.
// Sticky flags report overwritten samples, framing violations and frames
// whose term count differs from NTERMS.
module mac_acc_round_sat #(
    parameter int PSIZE  = 33,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15,
    parameter int NTERMS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mac_acc_round_sat_if.slave   bus,
    input  logic                 clr_err,
    output logic                 err_overrun,
    output logic                 err_seq,
    output logic                 err_count
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    localparam logic [15:0] CNT_MAX    = 16'hFFFF;
    localparam logic [15:0] CNT_ONE    = 16'd1;
    localparam logic [15:0] CNT_TARGET = 16'(NTERMS);

    // Half an output LSB, added before the shift so truncation rounds half-up.
    localparam logic [ACC_W:0] RND_WIDE = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

    // Clamp limits of the signed output range, expressed at rounding width.
    localparam logic signed [ACC_W:0] SAT_MAX =
        $signed({{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}});
    localparam logic signed [ACC_W:0] SAT_MIN =
        $signed({{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}});

    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    // Frame state.
    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [15:0]      cnt_q,   cnt_d;

    // Output register.
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic             out_sat_q,   out_sat_d;

    // Sticky error flags.
    logic             err_overrun_q, err_overrun_d;
    logic             err_seq_q,     err_seq_d;
    logic             err_count_q,   err_count_d;

    // Datapath intermediates.
    logic [ACC_W-1:0]        p_ext;
    logic [ACC_W-1:0]        acc_sum;
    logic [15:0]             cnt_inc;

    logic                    fin_valid;
    logic [ACC_W-1:0]        fin_sum;
    logic [15:0]             fin_cnt;
    logic                    seq_evt;

    logic signed [ACC_W:0]   s_wide;
    logic signed [ACC_W:0]   r_wide;
    logic [OUT_W-1:0]        sample_data;
    logic                    sample_sat;

    logic                    overrun_evt;
    logic                    count_evt;

    // Sign-extend the incoming term and form the running sum and next count.
    always_comb begin
        p_ext   = ACC_W'(bus.p);
        acc_sum = acc_q + p_ext;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end

    // Framing FSM: decides what each in_valid beat does to the accumulator
    // and whether it closes a frame (fin_valid with the final sum and count).
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        fin_valid = 1'b0;
        fin_sum   = acc_sum;
        fin_cnt   = cnt_inc;
        seq_evt   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_first) begin
                        acc_d = p_ext;
                        cnt_d = CNT_ONE;
                        if (bus.in_last) begin
                            fin_valid = 1'b1;
                            fin_sum   = p_ext;
                            fin_cnt   = CNT_ONE;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        seq_evt = 1'b1;
                    end
                end
            end

            ST_ACCUM: begin
                if (bus.in_valid) begin
                    if (bus.in_first) begin
                        seq_evt = 1'b1;
                        acc_d   = p_ext;
                        cnt_d   = CNT_ONE;
                        if (bus.in_last) begin
                            fin_valid = 1'b1;
                            fin_sum   = p_ext;
                            fin_cnt   = CNT_ONE;
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_inc;
                        if (bus.in_last) begin
                            fin_valid = 1'b1;
                            fin_sum   = acc_sum;
                            fin_cnt   = cnt_inc;
                            state_d   = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Round half-up, arithmetic shift and clamp the frame sum to OUT_W bits.
    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        s_wide = $signed({fin_sum[ACC_W-1], fin_sum}) + $signed(RND_WIDE);
        r_wide = s_wide >>> SHIFT;

        if (r_wide > SAT_MAX) begin
            sample_data = OUT_MAX;
            sample_sat  = 1'b1;
        end else if (r_wide < SAT_MIN) begin
            sample_data = OUT_MIN;
            sample_sat  = 1'b1;
        end else begin
            sample_data = r_wide[OUT_W-1:0];
            sample_sat  = 1'b0;
        end
    end

    // Output register: a new sample always loads; otherwise a handshake empties it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        overrun_evt = 1'b0;

        if (fin_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = sample_data;
            out_sat_d   = sample_sat;
            overrun_evt = out_valid_q && !bus.out_ready;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Sticky flags: a new event wins over a simultaneous clear.
    always_comb begin
        count_evt     = fin_valid && (fin_cnt != CNT_TARGET);
        err_overrun_d = overrun_evt | (err_overrun_q & ~clr_err);
        err_seq_d     = seq_evt     | (err_seq_q     & ~clr_err);
        err_count_d   = count_evt   | (err_count_q   & ~clr_err);
    end

    // State, accumulator, output and flag registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sat_q     <= 1'b0;
            err_overrun_q <= 1'b0;
            err_seq_q     <= 1'b0;
            err_count_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sat_q     <= out_sat_d;
            err_overrun_q <= err_overrun_d;
            err_seq_q     <= err_seq_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign err_overrun   = err_overrun_q;
    assign err_seq       = err_seq_q;
    assign err_count     = err_count_q;

endmodule
